// File: rtl/gr_heep_pkg.sv
// gr_heep_pkg: shared external-crossbar sizing constants and the arbiter state type
package gr_heep_pkg;
  localparam int unsigned ExtXbarNMaster = 2;
  localparam int unsigned ExtXbarNMasterRnd = ExtXbarNMaster == 0 ? 1 : ExtXbarNMaster;
  localparam int unsigned LogExtXbarNMaster = ExtXbarNMasterRnd > 1 ? $clog2(ExtXbarNMasterRnd) : 1;
  localparam int unsigned ExtObiMaxOutstanding = 4;
  typedef enum logic {IDLE, HOLD} ext_arb_state_e;
endpackage

// File: rtl/ext_obi_rsp_fifo.sv
// ext_obi_rsp_fifo: non-fall-through response-routing FIFO (clk_i, rst_ni active-low sync; i_push/i_data in, i_pop in, o_full/o_empty/o_head out)
module ext_obi_rsp_fifo
  import gr_heep_pkg::*;
#(
  parameter int unsigned IdxWidth = LogExtXbarNMaster,
  parameter int unsigned Depth = ExtObiMaxOutstanding
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic [IdxWidth-1:0] i_data,
  output logic                o_full,
  output logic                o_empty,
  output logic [IdxWidth-1:0] o_head
);
  localparam int unsigned PW = $clog2(Depth);
  logic [PW:0] r_wr, r_rd;
  logic [IdxWidth-1:0] r_mem [Depth];
  logic w_push, w_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full = (r_wr ^ r_rd) == {1'b1, {PW{1'b0}}};
  assign o_head = r_mem[r_rd[PW-1:0]];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end
  always_ff @(posedge clk_i) if (w_push) r_mem[r_wr[PW-1:0]] <= i_data;
endmodule

// File: rtl/ext_obi_rr_arbiter.sv
// ext_obi_rr_arbiter: round-robin OBI arbiter, m_* masters -> s_* slave, FIFO-routed m_rvalid_o, sticky err_o; EXT_OBI_ARB_PRIO_EN gives master 0 fixed priority
module ext_obi_rr_arbiter
  import gr_heep_pkg::*;
#(
  parameter int unsigned NMaster = ExtXbarNMasterRnd,
  parameter int unsigned MaxOutstanding = ExtObiMaxOutstanding,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NMaster-1:0]                    m_req_i,
  input  logic [NMaster-1:0]                    m_we_i,
  input  logic [NMaster-1:0][DataWidth/8-1:0]   m_be_i,
  input  logic [NMaster-1:0][AddrWidth-1:0]     m_addr_i,
  input  logic [NMaster-1:0][DataWidth-1:0]     m_wdata_i,
  output logic [NMaster-1:0]                    m_gnt_o,
  output logic [NMaster-1:0]                    m_rvalid_o,
  output logic [DataWidth-1:0]                  m_rdata_o,
  output logic                                  s_req_o,
  output logic                                  s_we_o,
  output logic [DataWidth/8-1:0]                s_be_o,
  output logic [AddrWidth-1:0]                  s_addr_o,
  output logic [DataWidth-1:0]                  s_wdata_o,
  input  logic                                  s_gnt_i,
  input  logic                                  s_rvalid_i,
  input  logic [DataWidth-1:0]                  s_rdata_i,
  output logic                                  err_o
);
  localparam int unsigned IW = NMaster > 1 ? $clog2(NMaster) : 1;
  ext_arb_state_e r_state, w_state_n;
  logic [IW-1:0] r_rr_ptr, r_sel, w_win, w_sel, w_head;
  logic w_any, w_full, w_empty, w_grant, w_pop, w_adv, r_err;
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = int'(NMaster) - 1; k >= 0; k--) begin
      w_win = m_req_i[IW'((int'(r_rr_ptr) + k) % int'(NMaster))] ? IW'((int'(r_rr_ptr) + k) % int'(NMaster)) : w_win;
      w_any = w_any | m_req_i[IW'((int'(r_rr_ptr) + k) % int'(NMaster))];
    end
`ifdef EXT_OBI_ARB_PRIO_EN
    w_win = m_req_i[0] ? '0 : w_win;
`endif
  end
  assign w_sel = r_state == HOLD ? r_sel : w_win;
  // full is checked only on entry; a held request has its slot reserved
  assign s_req_o = rst_ni && (r_state == HOLD || (w_any && !w_full));
  assign s_we_o = rst_ni && m_we_i[w_sel];
  assign s_be_o = rst_ni ? m_be_i[w_sel] : '0;
  assign s_addr_o = rst_ni ? m_addr_i[w_sel] : '0;
  assign s_wdata_o = rst_ni ? m_wdata_i[w_sel] : '0;
  assign w_grant = s_req_o && s_gnt_i;
  assign w_pop = rst_ni && s_rvalid_i && !w_empty;
  assign m_gnt_o = w_grant ? NMaster'(1) << w_sel : '0;
  assign m_rvalid_o = w_pop ? NMaster'(1) << w_head : '0;
  assign m_rdata_o = s_rdata_i;
  assign err_o = r_err;
`ifdef EXT_OBI_ARB_PRIO_EN
  assign w_adv = w_grant && w_sel != '0;
`else
  assign w_adv = w_grant;
`endif
  always_comb begin
    w_state_n = r_state;
    w_state_n = r_state == IDLE ? (s_req_o && !s_gnt_i ? HOLD : IDLE) : (s_gnt_i ? IDLE : HOLD);
  end
  always_ff @(posedge clk_i) r_state <= !rst_ni ? IDLE : w_state_n;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
      r_sel <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_adv) r_rr_ptr <= IW'((int'(w_sel) + 1) % int'(NMaster));
      if (r_state == IDLE && s_req_o && !s_gnt_i) r_sel <= w_win;
      if (s_rvalid_i && w_empty) r_err <= 1'b1;
    end
  end
  ext_obi_rsp_fifo #(.IdxWidth(IW), .Depth(MaxOutstanding)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_grant),
    .i_pop   (w_pop),
    .i_data  (w_sel),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );
endmodule

// File: tb/tb_ext_obi_rr_arbiter.sv
// tb_ext_obi_rr_arbiter: directed plus randomized checks of ext_obi_rr_arbiter against a queue-based reference model
module tb_ext_obi_rr_arbiter;
  localparam int N = 3;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] m_req = '0, m_we = '0;
  logic [N-1:0][3:0] m_be = '0;
  logic [N-1:0][31:0] m_addr = '0, m_wdata = '0;
  logic [N-1:0] m_gnt, m_rvalid;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata = '0;
  logic [3:0] s_be;
  logic s_req, s_we, s_gnt = 1'b0, s_rvalid = 1'b0, err;
  int tests = 0, fails = 0;
  bit mh = 0, merr = 0;
  int msel = 0, mptr = 0;
  int q[$];
  always #5 clk = ~clk;
  ext_obi_rr_arbiter #(.NMaster(N), .MaxOutstanding(DEPTH), .AddrWidth(32), .DataWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be),
    .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid),
    .m_rdata_o(m_rdata), .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr),
    .s_wdata_o(s_wdata), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .err_o(err)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    int w;
    bit any, sreq, g;
    @(negedge clk);
    any = 0;
    w = 0;
    if (mh) begin
      w = msel;
      any = 1;
    end else begin
      for (int k = 0; k < N; k++)
        if (!any && m_req[(mptr + k) % N]) begin
          w = (mptr + k) % N;
          any = 1;
        end
`ifdef EXT_OBI_ARB_PRIO_EN
      if (m_req[0]) w = 0;
`endif
    end
    sreq = rst_n && (mh || (any && q.size() < DEPTH));
    g = sreq && s_gnt;
    chk("s_req", s_req, sreq);
    chk("m_gnt", m_gnt, g ? 64'(1 << w) : 64'd0);
    chk("m_rvalid", m_rvalid, (rst_n && s_rvalid && q.size() > 0) ? 64'(1 << q[0]) : 64'd0);
    chk("m_rdata", m_rdata, s_rdata);
    chk("err", err, merr);
    if (sreq) begin
      chk("s_addr", s_addr, m_addr[w]);
      chk("s_we", s_we, m_we[w]);
      chk("s_be", s_be, m_be[w]);
      chk("s_wdata", s_wdata, m_wdata[w]);
    end
    if (!rst_n) chk("rst_chan", {s_we, s_be, s_addr, s_wdata}, 64'd0);
    @(posedge clk);
    if (!rst_n) begin
      mh = 0; msel = 0; mptr = 0; merr = 0;
      q.delete();
    end else begin
      if (s_rvalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1;
      end
      if (g) begin
        q.push_back(w);
        mh = 0;
`ifdef EXT_OBI_ARB_PRIO_EN
        if (w != 0) mptr = (w + 1) % N;
`else
        mptr = (w + 1) % N;
`endif
      end else if (sreq) begin
        mh = 1;
        msel = w;
      end
    end
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0; m_req = '0; s_gnt = 0; s_rvalid = 0;
    step();
    rst_n = 1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    do_reset();
    #1 chk("rst_err", err, 1'b0);
    for (int i = 0; i < N; i++) begin
      m_addr[i] = 32'h100 * (i + 1);
      m_wdata[i] = 32'hA0 + i;
      m_be[i] = 4'hF;
      m_we[i] = i[0];
    end
    m_req = 3'b011; s_gnt = 1;
    step();
    s_rvalid = 1;
    for (int i = 0; i < 5; i++) begin
      s_rdata = 32'hD000 + i;
      #1 chk("alt_gnt", m_gnt, (i % 2 == 0) ? 3'b010 : 3'b001);
      step();
    end
    do_reset();
    m_addr[1] = 32'h1000; m_req = 3'b010; s_gnt = 0;
    #1 chk("hold_addr", s_addr, 32'h1000);
    step();
    m_req = 3'b011;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) s_gnt = 1;
      #1 chk("hold_addr", s_addr, 32'h1000);
      chk("hold_gnt", m_gnt, i == 2 ? 3'b010 : 3'b000);
      step();
    end
    #1 chk("after_hold_gnt", m_gnt, 3'b001);
    step();
    do_reset();
    m_req = 3'b001; s_gnt = 1;
    repeat (DEPTH) step();
    #1 chk("full_sreq", s_req, 1'b0);
    step();
    s_rvalid = 1;
    #1 chk("full_pop_sreq", s_req, 1'b0);
    step();
    s_rvalid = 0;
    #1 chk("refill_sreq", s_req, 1'b1);
    step();
    do_reset();
    s_rvalid = 1;
    #1 chk("empty_rvalid", m_rvalid, 3'b000);
    step();
    s_rvalid = 0;
    #1 chk("err_set", err, 1'b1);
    repeat (3) step();
    chk("err_sticky", err, 1'b1);
    do_reset();
    #1 chk("err_clr", err, 1'b0);
    m_req = 3'b001; s_gnt = 1;
    repeat (2) step();
    m_req = 3'b010; s_gnt = 0;
    step();
    rst_n = 0;
    step();
    rst_n = 1; m_req = 3'b110; s_gnt = 1;
    #1 chk("post_rst_gnt", m_gnt, 3'b010);
    step();
    m_req = 3'b000; s_gnt = 0; s_rvalid = 1;
    step();
    s_rvalid = 0;
    step();
    s_rvalid = 1;
    step();
    s_rvalid = 0;
    #1 chk("late_rvalid_err", err, 1'b1);
`ifdef EXT_OBI_ARB_PRIO_EN
    do_reset();
    m_req = 3'b111; s_gnt = 1; s_rvalid = 1;
    repeat (3) begin
      #1 chk("prio_gnt", m_gnt, 3'b001);
      step();
    end
    m_req = 3'b110;
    repeat (4) step();
`endif
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 59) != 0;
      m_req = N'($urandom());
      m_we = N'($urandom());
      for (int j = 0; j < N; j++) begin
        m_be[j] = 4'($urandom());
        m_addr[j] = $urandom();
        m_wdata[j] = $urandom();
      end
      s_gnt = $urandom_range(0, 2) != 0;
      s_rvalid = $urandom_range(0, 2) == 0;
      s_rdata = $urandom();
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
